// File: rtl/id_ex_operand_stage_if.sv
// Decode/execute bus for the ID/EX operand stage: decoded instruction fields,
// EX/MEM and MEM/WB writeback taps, and the operands handed to the ALU.
interface id_ex_operand_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            id_valid_i;
    logic [XLEN-1:0] id_pc_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [RA_W-1:0] id_rs1_addr_i;
    logic [RA_W-1:0] id_rs2_addr_i;
    logic [RA_W-1:0] id_rd_addr_i;
    logic            id_use_rs1_i;
    logic            id_use_rs2_i;
    logic [3:0]      id_alu_sel_i;
    logic            id_a_sel_i;
    logic            id_b_sel_i;
    logic            id_reg_wen_i;
    logic            id_mem_rd_i;
    logic            id_mem_wr_i;

    logic [RA_W-1:0] exm_rd_i;
    logic            exm_wen_i;
    logic [XLEN-1:0] exm_result_i;
    logic [RA_W-1:0] mwb_rd_i;
    logic            mwb_wen_i;
    logic [XLEN-1:0] mwb_data_i;

    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [3:0]      alu_sel_o;
    logic [XLEN-1:0] store_data_o;
    logic [XLEN-1:0] pc_o;
    logic [RA_W-1:0] rd_o;
    logic            valid_o;
    logic            reg_wen_o;
    logic            mem_rd_o;
    logic            mem_wr_o;

    // Decode side / pipeline environment
    modport master (
        output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_use_rs1_i, id_use_rs2_i,
               id_alu_sel_i, id_a_sel_i, id_b_sel_i, id_reg_wen_i, id_mem_rd_i, id_mem_wr_i,
               exm_rd_i, exm_wen_i, exm_result_i, mwb_rd_i, mwb_wen_i, mwb_data_i,
        input  alu_a_o, alu_b_o, alu_sel_o, store_data_o, pc_o, rd_o, valid_o,
               reg_wen_o, mem_rd_o, mem_wr_o
    );

    // Operand stage
    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_use_rs1_i, id_use_rs2_i,
               id_alu_sel_i, id_a_sel_i, id_b_sel_i, id_reg_wen_i, id_mem_rd_i, id_mem_wr_i,
               exm_rd_i, exm_wen_i, exm_result_i, mwb_rd_i, mwb_wen_i, mwb_data_i,
        output alu_a_o, alu_b_o, alu_sel_o, store_data_o, pc_o, rd_o, valid_o,
               reg_wen_o, mem_rd_o, mem_wr_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand selection and hazard stall detection.
// Build option OPERAND_FORWARDING_EN: when defined, EX/MEM and MEM/WB results are
// forwarded and only load-use hazards stall; when undefined, operands come straight
// from the latched register-file data and any RAW hazard on a used source stalls.
module id_ex_operand_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    id_ex_operand_stage_if.slave   bus,
    output logic                   hazard_stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
`ifdef OPERAND_FORWARDING_EN
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
`endif
        logic [RA_W-1:0] rd;
        logic [3:0]      alu_sel;
        logic            a_sel;
        logic            b_sel;
        logic            reg_wen;
        logic            mem_rd;
        logic            mem_wr;
    } ex_reg_t;

    localparam ex_reg_t BUBBLE = '0;

    ex_reg_t                ex_q, ex_d, id_pkt;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hazard;
    logic [XLEN-1:0]        fwd_rs1, fwd_rs2;

    // Pack the decode-stage fields into the ID/EX record
    always_comb begin
        id_pkt          = BUBBLE;
        id_pkt.valid    = bus.id_valid_i;
        id_pkt.pc       = bus.id_pc_i;
        id_pkt.rs1_data = bus.id_rs1_data_i;
        id_pkt.rs2_data = bus.id_rs2_data_i;
        id_pkt.imm      = bus.id_imm_i;
`ifdef OPERAND_FORWARDING_EN
        id_pkt.rs1      = bus.id_rs1_addr_i;
        id_pkt.rs2      = bus.id_rs2_addr_i;
`endif
        id_pkt.rd       = bus.id_rd_addr_i;
        id_pkt.alu_sel  = bus.id_alu_sel_i;
        id_pkt.a_sel    = bus.id_a_sel_i;
        id_pkt.b_sel    = bus.id_b_sel_i;
        id_pkt.reg_wen  = bus.id_reg_wen_i;
        id_pkt.mem_rd   = bus.id_mem_rd_i;
        id_pkt.mem_wr   = bus.id_mem_wr_i;
    end

`ifdef OPERAND_FORWARDING_EN
    logic rs1_hit, rs2_hit;

    // Load-use hazard: a load in EX whose result the decoding instruction needs
    always_comb begin
        rs1_hit = bus.id_use_rs1_i && (bus.id_rs1_addr_i == ex_q.rd);
        rs2_hit = bus.id_use_rs2_i && (bus.id_rs2_addr_i == ex_q.rd);
        hazard  = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) && bus.id_valid_i
                  && (rs1_hit || rs2_hit) && !flush_i;
    end

    // Forwarding muxes: EX/MEM beats MEM/WB beats register file; x0 is always zero
    always_comb begin
        if (ex_q.rs1 == '0)
            fwd_rs1 = '0;
        else if (bus.exm_wen_i && (bus.exm_rd_i == ex_q.rs1))
            fwd_rs1 = bus.exm_result_i;
        else if (bus.mwb_wen_i && (bus.mwb_rd_i == ex_q.rs1))
            fwd_rs1 = bus.mwb_data_i;
        else
            fwd_rs1 = ex_q.rs1_data;

        if (ex_q.rs2 == '0)
            fwd_rs2 = '0;
        else if (bus.exm_wen_i && (bus.exm_rd_i == ex_q.rs2))
            fwd_rs2 = bus.exm_result_i;
        else if (bus.mwb_wen_i && (bus.mwb_rd_i == ex_q.rs2))
            fwd_rs2 = bus.mwb_data_i;
        else
            fwd_rs2 = ex_q.rs2_data;
    end
`else
    logic rs1_raw, rs2_raw;

    // Any in-flight writer of a used, non-zero source forces a stall
    always_comb begin
        rs1_raw = bus.id_use_rs1_i && (bus.id_rs1_addr_i != '0)
                  && ((ex_q.valid && ex_q.reg_wen && (ex_q.rd == bus.id_rs1_addr_i))
                   || (bus.exm_wen_i && (bus.exm_rd_i == bus.id_rs1_addr_i))
                   || (bus.mwb_wen_i && (bus.mwb_rd_i == bus.id_rs1_addr_i)));
        rs2_raw = bus.id_use_rs2_i && (bus.id_rs2_addr_i != '0)
                  && ((ex_q.valid && ex_q.reg_wen && (ex_q.rd == bus.id_rs2_addr_i))
                   || (bus.exm_wen_i && (bus.exm_rd_i == bus.id_rs2_addr_i))
                   || (bus.mwb_wen_i && (bus.mwb_rd_i == bus.id_rs2_addr_i)));
        hazard  = bus.id_valid_i && (rs1_raw || rs2_raw) && !flush_i;
    end

    // Without forwarding the operands are the latched register-file reads
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        fwd_rs2 = ex_q.rs2_data;
    end
`endif

    // Next-state: flush > hold > hazard bubble > load; saturating stall counter
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (hazard && (cnt_q != '1))
            cnt_d = cnt_q + STALL_CNT_W'(1);
        if (flush_i)
            ex_d = BUBBLE;
        else if (stall_i)
            ex_d = ex_q;
        else if (hazard)
            ex_d = BUBBLE;
        else
            ex_d = id_pkt;
    end

    // ID/EX register and stall counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Operand selection and registered copies toward EX
    always_comb begin
        bus.alu_a_o      = ex_q.a_sel ? ex_q.pc : fwd_rs1;
        bus.alu_b_o      = ex_q.b_sel ? ex_q.imm : fwd_rs2;
        bus.alu_sel_o    = ex_q.alu_sel;
        bus.store_data_o = fwd_rs2;
        bus.pc_o         = ex_q.pc;
        bus.rd_o         = ex_q.rd;
        bus.valid_o      = ex_q.valid;
        bus.reg_wen_o    = ex_q.reg_wen;
        bus.mem_rd_o     = ex_q.mem_rd;
        bus.mem_wr_o     = ex_q.mem_wr;
        hazard_stall_o   = hazard;
        stall_cnt_o      = cnt_q;
    end

    // ALU_ADD is the reset/bubble select value and equals the all-zero record field
    logic unused_add;
    assign unused_add = (ALU_ADD == 4'b0000);

endmodule
